// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the fetch queue
package fetch_queue_pkg;

   localparam int          FETCH_WIDTH_DEF = 2;
   localparam logic [31:0] INSTR_NOP_END   = 32'h0;

   typedef struct packed {
      logic [31:0] instr;
      logic [6:0]  pc;
   } fq_entry;

endpackage

// File: rtl/fq_ring.sv
// rtl/fq_ring.sv - multi-write/multi-read ring buffer of fq_entry records
module fq_ring
   import fetch_queue_pkg::*;
#(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int N_W   = $clog2(WIDTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [N_W-1:0]         wr_n,
   input  fq_entry [WIDTH-1:0]    wr_data,
   input  logic [N_W-1:0]         rd_n,
   output fq_entry [WIDTH-1:0]    rd_data,
   output logic [CNT_W-1:0]       count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   fq_entry          mem [DEPTH];

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(rd_n);
         tail  <= tail + PTR_W'(wr_n);
         count <= count + CNT_W'(wr_n) - CNT_W'(rd_n);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (!rst && !clr && (N_W'(i) < wr_n))
            mem[tail + PTR_W'(i)] <= wr_data[i];
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++)
         rd_data[i] = mem[head + PTR_W'(i)];
   end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage feeding decode through an in-order queue
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
   parameter int DEPTH       = 8,
   parameter int IMEM_BYTES  = 128,
   parameter int PC_W        = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic [PC_W-1:0]             imem_addr,
   input  logic [32*FETCH_WIDTH-1:0]   imem_data,
   input  logic                        deq_ready,
   output logic [FETCH_WIDTH-1:0]      deq_valid,
   output logic [32*FETCH_WIDTH-1:0]   deq_instr,
   output logic [PC_W*FETCH_WIDTH-1:0] deq_pc,
   input  logic                        flush,
   input  logic [PC_W-1:0]             flush_pc,
   output logic                        halted,
   output logic [31:0]                 fetched_count,
   output logic [31:0]                 cycle_count
);

   localparam int              CNT_W       = $clog2(DEPTH + 1);
   localparam int              N_W         = $clog2(FETCH_WIDTH + 1);
   localparam logic [PC_W-1:0] GROUP_BYTES = PC_W'(4 * FETCH_WIDTH);
   localparam logic [PC_W:0]   MEM_END     = (PC_W + 1)'(IMEM_BYTES);

   logic [PC_W-1:0]                pc;
   logic [CNT_W-1:0]               count;
   logic [N_W-1:0]                 scan_n;
   logic [N_W-1:0]                 wr_n;
   logic [N_W-1:0]                 rd_n;
   logic                           zero_seen;
   logic                           can_enq;
   logic                           end_of_mem;
   fq_entry [FETCH_WIDTH-1:0]      wr_data;
   fq_entry [FETCH_WIDTH-1:0]      rd_data;

   // Free space is judged on the start-of-cycle count; a same-cycle pop earns no credit.
   assign can_enq    = !halted && !flush &&
                       ((CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH));
   assign end_of_mem = ({1'b0, pc} + {1'b0, GROUP_BYTES}) >= MEM_END;
   assign wr_n       = can_enq ? scan_n : '0;

   always_comb begin
      scan_n    = '0;
      zero_seen = 1'b0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         wr_data[i].instr = imem_data[32*i +: 32];
         wr_data[i].pc    = pc + PC_W'(4 * i);
         if (!zero_seen) begin
            if (imem_data[32*i +: 32] == INSTR_NOP_END)
               zero_seen = 1'b1;
            else
               scan_n = N_W'(i + 1);
         end
      end
   end

   always_comb begin
      rd_n = '0;
      if (deq_ready && !flush && (count != '0))
         rd_n = (count >= CNT_W'(FETCH_WIDTH)) ? N_W'(FETCH_WIDTH) : N_W'(count);
   end

   fq_ring #(
      .WIDTH (FETCH_WIDTH),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .wr_n    (wr_n),
      .wr_data (wr_data),
      .rd_n    (rd_n),
      .rd_data (rd_data),
      .count   (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= '0;
         halted        <= 1'b0;
         fetched_count <= '0;
         cycle_count   <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (flush) begin
            pc            <= flush_pc;
            halted        <= 1'b0;
            fetched_count <= '0;
         end else if (can_enq) begin
            fetched_count <= fetched_count + 32'(scan_n);
            // No wrap past the top of memory: the last group halts fetch like a zero word.
            if (zero_seen || end_of_mem)
               halted <= 1'b1;
            else
               pc <= pc + GROUP_BYTES;
         end
      end
   end

   assign imem_addr = pc;

   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         deq_valid[i]                = count > CNT_W'(i);
         deq_instr[32*i +: 32]       = rd_data[i].instr;
         deq_pc[PC_W*i +: PC_W]      = rd_data[i].pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

   localparam int FW         = 2;
   localparam int DEPTH      = 8;
   localparam int IMEM_BYTES = 128;
   localparam int PC_W       = 7;
   localparam int NWORDS     = IMEM_BYTES / 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [PC_W-1:0]      imem_addr;
   logic [32*FW-1:0]     imem_data;
   logic                 deq_ready;
   logic [FW-1:0]        deq_valid;
   logic [32*FW-1:0]     deq_instr;
   logic [PC_W*FW-1:0]   deq_pc;
   logic                 flush;
   logic [PC_W-1:0]      flush_pc;
   logic                 halted;
   logic [31:0]          fetched_count;
   logic [31:0]          cycle_count;

   logic [31:0] mem [NWORDS];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < FW; i++)
         imem_data[32*i +: 32] = mem[(int'(imem_addr) / 4 + i) % NWORDS];
   end

   fetch_queue #(
      .FETCH_WIDTH (FW),
      .DEPTH       (DEPTH),
      .IMEM_BYTES  (IMEM_BYTES),
      .PC_W        (PC_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .deq_ready     (deq_ready),
      .deq_valid     (deq_valid),
      .deq_instr     (deq_instr),
      .deq_pc        (deq_pc),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .halted        (halted),
      .fetched_count (fetched_count),
      .cycle_count   (cycle_count)
   );

   typedef struct {
      logic [31:0] instr;
      int          pc;
   } ent_t;

   ent_t        mq[$];
   int          m_pc;
   bit          m_halted;
   logic [31:0] m_fetched;
   logic [31:0] m_cycles;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] mword(input int addr);
      return mem[(addr / 4) % NWORDS];
   endfunction

   task automatic model_step(input bit r, input bit f, input int fpc, input bit rdy);
      ent_t add[$];
      int   ndeq;
      bit   zero;
      if (r) begin
         mq.delete();
         m_pc = 0; m_halted = 0; m_fetched = 0; m_cycles = 0;
         return;
      end
      m_cycles = m_cycles + 32'd1;
      if (f) begin
         mq.delete();
         m_pc = fpc; m_halted = 0; m_fetched = 0;
         return;
      end
      ndeq = rdy ? ((mq.size() < FW) ? mq.size() : FW) : 0;
      if (!m_halted && (DEPTH - mq.size()) >= FW) begin
         zero = 0;
         for (int i = 0; i < FW && !zero; i++) begin
            if (mword(m_pc + 4*i) == 32'h0) zero = 1;
            else add.push_back('{mword(m_pc + 4*i), m_pc + 4*i});
         end
         if (zero || (m_pc + 4*FW >= IMEM_BYTES)) m_halted = 1;
         else m_pc = m_pc + 4*FW;
         m_fetched = m_fetched + 32'(add.size());
      end
      repeat (ndeq) void'(mq.pop_front());
      foreach (add[k]) mq.push_back(add[k]);
   endtask

   task automatic check_model();
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("fetched_count", fetched_count, m_fetched);
      chk("cycle_count", cycle_count, m_cycles);
      for (int i = 0; i < FW; i++) begin
         chk($sformatf("deq_valid[%0d]", i), 32'(deq_valid[i]), 32'(i < mq.size()));
         if (i < mq.size()) begin
            chk($sformatf("deq_instr[%0d]", i), deq_instr[32*i +: 32], mq[i].instr);
            chk($sformatf("deq_pc[%0d]", i), 32'(deq_pc[PC_W*i +: PC_W]), 32'(mq[i].pc));
         end
      end
   endtask

   task automatic tick(input bit r, input bit f, input int fpc, input bit rdy);
      rst = r; flush = f; flush_pc = PC_W'(fpc); deq_ready = rdy;
      model_step(r, f, fpc, rdy);
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      bit          rdy;
      logic [1:0]  valid;
      int          pc0;
      bit          hlt;
      int          fetched;
      int          addr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      rst = 1'b1; flush = 1'b0; flush_pc = '0; deq_ready = 1'b0;
      tbl[0] = '{1'b1, 2'b00,  0, 1'b0, 0,  0};
      tbl[1] = '{1'b1, 2'b11,  0, 1'b0, 2,  8};
      tbl[2] = '{1'b1, 2'b11,  8, 1'b0, 4, 16};
      tbl[3] = '{1'b1, 2'b11, 16, 1'b0, 6, 24};
      tbl[4] = '{1'b1, 2'b01, 24, 1'b1, 7, 24};
      tbl[5] = '{1'b1, 2'b00,  0, 1'b1, 7, 24};
      @(negedge clk);

      // Streaming into a zero word at pc 28
      for (int k = 0; k < NWORDS; k++) mem[k] = (k < 7) ? (32'hA000_0000 | 32'(k + 1)) : 32'h0;
      tick(1, 0, 0, 0);
      for (int r = 0; r < 6; r++) begin
         chk($sformatf("stream%0d valid", r), 32'(deq_valid), 32'(tbl[r].valid));
         if (tbl[r].valid[0]) begin
            chk($sformatf("stream%0d pc0", r), 32'(deq_pc[PC_W-1:0]), 32'(tbl[r].pc0));
            chk($sformatf("stream%0d instr0", r), deq_instr[31:0], mem[tbl[r].pc0 / 4]);
         end
         chk($sformatf("stream%0d halted", r), 32'(halted), 32'(tbl[r].hlt));
         chk($sformatf("stream%0d fetched", r), fetched_count, 32'(tbl[r].fetched));
         chk($sformatf("stream%0d addr", r), 32'(imem_addr), 32'(tbl[r].addr));
         tick(0, 0, 0, tbl[r].rdy);
      end

      // Backpressure, then drain through wrap with simultaneous push/pop at count 6
      for (int k = 0; k < NWORDS; k++) mem[k] = 32'hC000_0000 | 32'(k * 4 + 1);
      tick(1, 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         tick(0, 0, 0, 0);
         chk("bp addr", 32'(imem_addr), 32'((8 * k < 32) ? 8 * k : 32));
         chk("bp instr0", deq_instr[31:0], mem[0]);
         chk("bp valid", 32'(deq_valid), 32'h3);
      end
      for (int k = 1; k <= 8; k++) begin
         tick(0, 0, 0, 1);
         chk("drain pc0", 32'(deq_pc[PC_W-1:0]), 32'(8 * k));
         chk("drain pc1", 32'(deq_pc[2*PC_W-1:PC_W]), 32'(8 * k + 4));
         chk("drain addr", 32'(imem_addr), 32'(32 + 8 * (k - 1)));
      end

      // Flush while halted with 5 entries queued
      for (int k = 0; k < NWORDS; k++) mem[k] = (k == 5) ? 32'h0 : (32'h5000_0000 | 32'(k));
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      chk("pre-flush halted", 32'(halted), 32'h1);
      chk("pre-flush addr", 32'(imem_addr), 32'd16);
      tick(0, 1, 40, 1);
      chk("flush valid", 32'(deq_valid), 32'h0);
      chk("flush halted", 32'(halted), 32'h0);
      chk("flush addr", 32'(imem_addr), 32'd40);
      chk("flush fetched", fetched_count, 32'h0);
      tick(0, 0, 0, 0);
      chk("post-flush valid", 32'(deq_valid), 32'h3);
      chk("post-flush pc0", 32'(deq_pc[PC_W-1:0]), 32'd40);

      // End of memory without wrap
      for (int k = 0; k < NWORDS; k++) mem[k] = 32'h7000_0000 | 32'(k + 1);
      tick(1, 0, 0, 0);
      repeat (20) tick(0, 0, 0, 1);
      chk("eom halted", 32'(halted), 32'h1);
      chk("eom addr", 32'(imem_addr), 32'd120);
      chk("eom fetched", fetched_count, 32'd32);
      chk("eom valid", 32'(deq_valid), 32'h0);

      // Reset mid-stream with 4 entries queued
      tick(1, 0, 0, 0);
      repeat (2) tick(0, 0, 0, 0);
      tick(1, 0, 0, 0);
      chk("rst valid", 32'(deq_valid), 32'h0);
      chk("rst halted", 32'(halted), 32'h0);
      chk("rst addr", 32'(imem_addr), 32'h0);
      chk("rst fetched", fetched_count, 32'h0);
      chk("rst cycles", cycle_count, 32'h0);
      tick(0, 0, 0, 0);
      chk("rst cycles restart", cycle_count, 32'd1);

      // Randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         bit r;
         bit f;
         bit rdy;
         int fpc;
         r   = ($urandom_range(0, 99) == 0);
         f   = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         fpc = 4 * int'($urandom_range(0, NWORDS - 1));
         if (n == 0 || r) begin
            r = 1'b1;
            for (int k = 0; k < NWORDS; k++)
               mem[k] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
         end
         tick(r, f, fpc, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
